instr_reader: RTL and testbench

//  Read-side sequencer for the 32-entry instruction register.
//  - On a start pulse it walks read_pointer from start_addr over count entries.
//  - It captures each instruction_word (opc, op_a, op_b, result) into output registers.
//  - It streams the captured words downstream on a valid/ready interface.
//  - Used by the lab DUT to drain stored instructions and their results into a checker or scoreboard.

---
 rtl/instr_reader_if.sv | 62 ++++++
 rtl/instr_reader.sv | 138 +++++++++++++
 tb/tb_instr_reader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_reader_if.sv
// Instruction-register types plus the reader's handshake/bus interface.
// Latency: n/a (declarations only).
// Backpressure: n/a; out_valid/out_ready defined here are honoured by instr_reader.

package instr_register_pkg;
  localparam int REG_DEPTH = 32;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0]            operand_t;
  typedef logic signed [63:0]            result_t;
  typedef logic [$clog2(REG_DEPTH)-1:0]  address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;
endpackage

interface instr_reader_if;
  import instr_register_pkg::*;

  // sweep control
  logic         start;
  address_t     start_addr;
  logic [5:0]   count;
  logic         abort;
  // register read port
  address_t     read_pointer;
  instruction_t instruction_word;
  // output stream
  logic         out_valid;
  logic         out_ready;
  instruction_t out_word;
  address_t     out_index;
  // status
  logic         busy;
  logic         done;

  // Reader side: drives the register address and the output stream.
  modport master (
    input  start, start_addr, count, abort, instruction_word, out_ready,
    output read_pointer, out_valid, out_word, out_index, busy, done
  );

  // Environment side: issues sweeps, serves the register read, sinks beats.
  modport slave (
    output start, start_addr, count, abort, instruction_word, out_ready,
    input  read_pointer, out_valid, out_word, out_index, busy, done
  );
endinterface

// File: rtl/instr_reader.sv
// Sweeps the instruction register from start_addr over count entries and streams each word out.
// Latency: start -> out_valid after 2 posedges; at most one beat every 2 cycles.
// Backpressure: out_word/out_index/read_pointer hold while out_valid && !out_ready.

module instr_reader
  import instr_register_pkg::*;
#(
  parameter int DEPTH = instr_register_pkg::REG_DEPTH,  // must match address_t range
  parameter int CNT_W = 6                               // must be able to hold DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  instr_reader_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_t;

  localparam instruction_t WORD_RST = '{opc: ZERO, default: '0};
  localparam address_t     LAST_ADDR = address_t'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  address_t           read_pointer_q, read_pointer_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               out_valid_q, out_valid_d;
  instruction_t       out_word_q, out_word_d;
  address_t           out_index_q, out_index_d;
  logic               done_q, done_d;

  logic               handshake;
  logic               last_beat;

  assign handshake = out_valid_q && bus.out_ready;
  assign last_beat = (remaining_q == CNT_W'(1));

  // State register; busy is registered alongside so it tracks state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; abort overrides everything, including a coincident start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) state_d = FETCH;
      end
      FETCH: begin
        state_d = bus.abort ? IDLE : SEND;
      end
      SEND: begin
        if (bus.abort)               state_d = IDLE;
        else if (handshake)          state_d = last_beat ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Datapath/output next values: load on start, capture in FETCH, advance on handshake.
  always_comb begin
    read_pointer_d = read_pointer_q;
    remaining_d    = remaining_q;
    out_valid_d    = out_valid_q;
    out_word_d     = out_word_q;
    out_index_d    = out_index_q;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          read_pointer_d = bus.start_addr;
          // zero and oversize counts both mean a full sweep
          remaining_d    = (bus.count == '0 || bus.count > DEPTH_CNT) ? DEPTH_CNT : bus.count;
        end
      end
      FETCH: begin
        if (!bus.abort) begin
          out_word_d  = bus.instruction_word;
          out_index_d = read_pointer_q;
          out_valid_d = 1'b1;
        end
      end
      SEND: begin
        if (bus.abort) begin
          // a beat accepted in the abort cycle still counts, but the sweep ends silently
          out_valid_d = 1'b0;
        end else if (handshake) begin
          out_valid_d = 1'b0;
          if (last_beat) begin
            done_d = 1'b1;
          end else begin
            remaining_d    = remaining_q - CNT_W'(1);
            read_pointer_d = (read_pointer_q == LAST_ADDR) ? '0 : read_pointer_q + address_t'(1);
          end
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  // Datapath registers with synchronous reset to idle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_pointer_q <= '0;
      remaining_q    <= '0;
      out_valid_q    <= 1'b0;
      out_word_q     <= WORD_RST;
      out_index_q    <= '0;
      done_q         <= 1'b0;
    end else begin
      read_pointer_q <= read_pointer_d;
      remaining_q    <= remaining_d;
      out_valid_q    <= out_valid_d;
      out_word_q     <= out_word_d;
      out_index_q    <= out_index_d;
      done_q         <= done_d;
    end
  end

  assign bus.read_pointer = read_pointer_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_word     = out_word_q;
  assign bus.out_index    = out_index_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_instr_reader.sv
// Directed bench for instr_reader with a behavioural 32-entry register.
// Latency: drives inputs and samples outputs 1 time unit after each posedge.
// Backpressure: out_ready driven per test to exercise stall and abort paths.

module tb_instr_reader;
  import instr_register_pkg::*;

  logic clk;
  logic reset;
  instr_reader_if bus ();

  instr_reader #(.DEPTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  instruction_t mem [32];
  assign bus.instruction_word = mem[bus.read_pointer];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int      beat_idx [$];
  longint  beat_res [$];
  int      beat_cyc [$];
  int      n_done;
  int      done_cyc;

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts beats (out_ready as currently driven) until done plus two quiet cycles.
  task automatic run_sweep(input string tag, input int budget);
    bit seen;
    int after;
    beat_idx.delete();
    beat_res.delete();
    beat_cyc.delete();
    n_done   = 0;
    done_cyc = -1;
    seen     = 1'b0;
    after    = 0;
    for (int c = 0; c < budget; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        beat_idx.push_back(int'(bus.out_index));
        beat_res.push_back(longint'(bus.out_word.result));
        beat_cyc.push_back(c);
      end
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        seen = 1'b1;
      end
      tick();
      if (seen) begin
        after++;
        if (after == 3) break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic start_sweep(input int addr, input int cnt);
    bus.start_addr = address_t'(addr);
    bus.count      = 6'(cnt);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < 32; i++) begin
      mem[i] = '{opc: PASSA, op_a: 32'(i), op_b: 32'sd0, result: 64'(1000 + i)};
    end
    mem[0] = '{opc: ADD,  op_a: 32'sd5, op_b: 32'sd3, result: 64'sd8};
    mem[1] = '{opc: SUB,  op_a: 32'sd9, op_b: 32'sd4, result: 64'sd5};
    mem[2] = '{opc: MULT, op_a: 32'sd6, op_b: 32'sd7, result: 64'sd42};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.count = '0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rp", bus.read_pointer, 0);
    check("rst_word", bus.out_word, 160'd0);

    // 1: three beats from addr 0, one every 2 cycles, done right after the last
    bus.out_ready = 1'b1;
    start_sweep(0, 3);
    check("t1_busy", bus.busy, 1);
    check("t1_valid_fetch", bus.out_valid, 0);
    run_sweep("t1", 40);
    check("t1_nbeats", beat_idx.size(), 3);
    if (beat_idx.size() == 3) begin
      check("t1_idx0", beat_idx[0], 0);
      check("t1_idx2", beat_idx[2], 2);
      check("t1_res0", beat_res[0], 8);
      check("t1_res1", beat_res[1], 5);
      check("t1_res2", beat_res[2], 42);
      check("t1_cyc0", beat_cyc[0], 1);
      check("t1_cyc2", beat_cyc[2], 5);
    end
    check("t1_done_cyc", done_cyc, 6);
    check("t1_ndone", n_done, 1);
    check("t1_idle", bus.busy, 0);

    // 2: wrap 30,31,0,1
    start_sweep(30, 4);
    run_sweep("t2", 40);
    check("t2_nbeats", beat_idx.size(), 4);
    if (beat_idx.size() == 4) begin
      check("t2_idx1", beat_idx[1], 31);
      check("t2_idx2", beat_idx[2], 0);
      check("t2_idx3", beat_idx[3], 1);
      check("t2_res1", beat_res[1], 1031);
      check("t2_res3", beat_res[3], 5);
    end
    check("t2_ndone", n_done, 1);

    // 3: stall 5 cycles in SEND, then resume
    bus.out_ready = 1'b0;
    start_sweep(5, 2);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", bus.out_valid, 1);
      check("t3_hold_idx", bus.out_index, 5);
      check("t3_hold_rp", bus.read_pointer, 5);
      check("t3_hold_res", bus.out_word.result, 1005);
      tick();
    end
    bus.out_ready = 1'b1;
    run_sweep("t3", 40);
    check("t3_nbeats", beat_idx.size(), 2);
    if (beat_idx.size() == 2) begin
      check("t3_idx0", beat_idx[0], 5);
      check("t3_idx1", beat_idx[1], 6);
      check("t3_cyc1", beat_cyc[1], 2);
    end
    check("t3_done_cyc", done_cyc, 3);

    // 4: count 0 means a full 32-entry sweep
    start_sweep(0, 0);
    run_sweep("t4", 200);
    check("t4_nbeats", beat_idx.size(), 32);
    bad = 0;
    foreach (beat_idx[i]) if (beat_idx[i] != i) bad++;
    check("t4_idx_seq", bad, 0);
    if (beat_idx.size() == 32) begin
      check("t4_res2", beat_res[2], 42);
      check("t4_res31", beat_res[31], 1031);
    end
    check("t4_done_cyc", done_cyc, 64);
    check("t4_ndone", n_done, 1);

    // count above DEPTH clamps to a full sweep
    start_sweep(16, 40);
    run_sweep("t4c", 200);
    check("t4c_nbeats", beat_idx.size(), 32);
    if (beat_idx.size() == 32) begin
      check("t4c_first", beat_idx[0], 16);
      check("t4c_last", beat_idx[31], 15);
    end

    // 5: abort while 2nd of 4 beats is pending
    start_sweep(10, 4);
    tick();
    tick();
    tick();
    check("t5_idx_pending", bus.out_index, 11);
    bus.abort = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.abort = 1'b0;
    check("t5_valid", bus.out_valid, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_done", bus.done, 0);
    check("t5_rp_hold", bus.read_pointer, 11);
    bus.out_ready = 1'b1;
    start_sweep(20, 1);
    check("t5_restart_busy", bus.busy, 1);
    run_sweep("t5", 40);
    check("t5_nbeats", beat_idx.size(), 1);
    if (beat_idx.size() == 1) check("t5_idx", beat_idx[0], 20);
    check("t5_ndone", n_done, 1);

    // abort wins over a coincident start in IDLE
    bus.abort = 1'b1;
    start_sweep(3, 2);
    bus.abort = 1'b0;
    check("t5b_busy", bus.busy, 0);
    tick();
    check("t5b_valid", bus.out_valid, 0);

    // 6: start while busy is ignored
    start_sweep(0, 2);
    bus.start_addr = 5'd20;
    bus.count = 6'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_sweep("t6", 40);
    check("t6_nbeats", beat_idx.size(), 2);
    if (beat_idx.size() == 2) begin
      check("t6_idx0", beat_idx[0], 0);
      check("t6_idx1", beat_idx[1], 1);
    end
    check("t6_ndone", n_done, 1);

    // reset mid-sweep
    bus.out_ready = 1'b0;
    start_sweep(7, 5);
    tick();
    check("t6r_pre_valid", bus.out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6r_valid", bus.out_valid, 0);
    check("t6r_busy", bus.busy, 0);
    check("t6r_done", bus.done, 0);
    check("t6r_rp", bus.read_pointer, 0);
    check("t6r_idx", bus.out_index, 0);
    check("t6r_word", bus.out_word, 160'd0);
    tick();
    check("t6r_still_idle", bus.busy, 0);
    check("t6r_no_done", bus.done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
